sigma_np: RTL
=============

SIGMA_NP -- requirements
Module: sigma_np

Interface
REQ-001 SHALL have parameter DW, default 8, meaning input sample width including sign bit, legal range 4..16.
REQ-002 SHALL have parameter LOG2N, default 4, meaning log2 of samples per sum N (N = 2^LOG2N), legal range 1..8.
REQ-003 SHALL have parameter MODE, default 0, meaning 0 = block sum, 1 = sliding (moving) sum.
REQ-004 SHALL have parameter IN_FMT, default 0, meaning 0 = sign-magnitude input, 1 = two's-complement input.
REQ-005 SHALL have clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have res, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have data_in, input, DW, meaning sample value in the IN_FMT format.
REQ-008 SHALL have syn_in, input, 1, meaning sample strobe; only its rising edge is significant.
REQ-009 SHALL have clr, input, 1, meaning synchronous restart of accumulation, active-high.
REQ-010 SHALL have data_out, output, OW = DW+LOG2N, meaning two's-complement sum.
REQ-011 SHALL have syn_out, output, 1, meaning one-cycle pulse marking a new data_out.
REQ-012 SHALL have primed, output, 1, meaning the window holds N valid samples (MODE=1 only; tied 0 in MODE=0).

Function
REQ-013 SHALL define an event cycle as a clk edge where syn_in is sampled 1 and was sampled 0 at the previous edge; syn_in held high never produces more than one event.
REQ-014 SHALL convert each sample at the event edge into a registered OW-bit two's-complement value: IN_FMT=0 negates the magnitude when MSB=1 and maps -0 (MSB=1, magnitude 0) to 0; IN_FMT=1 sign-extends.
REQ-015 SHALL compute the sum at exact width OW; no saturation, no overflow possible.
REQ-016 SHALL, in MODE=0, count events 0..N-1 and, on the Nth event, output the sum of those N samples including the Nth, then restart the sum from zero for the next block.
REQ-017 SHALL, in MODE=1, store the last N converted samples in a circular buffer and on every event update sum = sum + new - oldest; syn_out fires on every event once primed, including the Nth.
REQ-018 SHALL update data_out and assert syn_out one clock after the event edge; syn_out is high for exactly one cycle; data_out holds between updates.
REQ-019 SHALL accept events at most every second cycle (inherent to edge detection) with no loss at that rate.
REQ-020 SHALL, when clr=1, zero the running sum, block count, buffer fill count and primed at that edge; an event in the same cycle is discarded; data_out keeps its last value; a syn_out already in flight is still delivered.
REQ-021 SHALL, in MODE=1, treat buffer slots as zero after reset/clr (subtraction of stale data is forbidden).

Reset
REQ-022 SHALL, while res=0, force data_out=0, syn_out=0, primed=0, sum=0, counts=0, and syn_in history to 1 so syn_in high across reset release generates no event.
REQ-023 SHALL discard any partial block or window on reset; the first output after reset needs N fresh events.

Structure
REQ-024 SHALL place MODE and IN_FMT encodings and an output-width function (DW+LOG2N) in shared package sigma_pkg.
REQ-025 SHALL implement the MODE=1 circular buffer (N x DW, one write plus one read per event, registered pointers) as sub-module sigma_np_dly, not instantiated when MODE=0.

Verification (DW=8, LOG2N=4)
REQ-026 SHALL cover MODE=0, IN_FMT=0: 16 events of 0x05 -> one syn_out, data_out=0x050; 16 of 0x85 -> 0xFB0.
REQ-027 SHALL cover extremes: 16 x 0x7F -> 0x7F0; 16 x 0xFF -> 0x810; 16 x 0x80 (-0) -> 0x000.
REQ-028 SHALL cover MODE=1: 15 events of 0x01 -> no syn_out, primed=0; 16th -> data_out=0x010, primed=1; 17th event 0x83 -> data_out=0x00C.
REQ-029 SHALL cover reset mid-block: 7 events of 0x05, pulse res low -> outputs 0; next 16 events of 0x01 -> data_out=0x010 only on 16th.
REQ-030 SHALL cover clr coincident with event after 5 events of 0x02: event dropped, no syn_out; then 16 events of 0x02 -> data_out=0x020.
REQ-031 SHALL cover IN_FMT=1 MODE=0: 16 x 0x80 -> 0x800; syn_in held high 10 cycles -> exactly one event counted.

Source files
------------

// File: rtl/sigma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_pkg
//  Description : Shared encodings and helpers for the sigma_np accumulator.
//                MODE and IN_FMT encodings plus the output-width function
//                used to size the two's-complement sum.
//  Revision    : 1.0 - initial release
// ============================================================================
package sigma_pkg;

    // MODE encodings
    localparam int c_mode_block = 0;   // non-overlapping block sum of N samples
    localparam int c_mode_slide = 1;   // moving sum over the last N samples

    // IN_FMT encodings
    localparam int c_fmt_sign_mag  = 0;
    localparam int c_fmt_twos_comp = 1;

    // Width of the sum: N = 2^log2n samples of at most 2^(dw-1) magnitude
    // never exceed a (dw+log2n)-bit two's-complement range.
    function automatic int out_width(input int dw, input int log2n);
        return dw + log2n;
    endfunction

endpackage : sigma_pkg
`default_nettype wire

// File: rtl/sigma_np_dly.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_np_dly
//  Description : N-deep circular sample buffer for the moving-sum mode.
//                rd_data is the slot at the write pointer, i.e. the oldest
//                stored sample, which is overwritten by wr_data on wr_en.
//  Ports       : clk     - clock
//                res     - asynchronous active-low reset
//                clr     - synchronous pointer restart
//                wr_en   - store wr_data and advance the pointer
//                wr_data - DW-bit two's-complement sample
//                rd_data - oldest sample (valid only once N samples written)
//  Revision    : 1.0 - initial release
// ============================================================================
module sigma_np_dly
    import sigma_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LOG2N = 4
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    localparam int N = 1 << LOG2N;

    logic [DW-1:0]    r_mem [N];
    logic [LOG2N-1:0] r_ptr;

    // Pointer wraps naturally at N since N is a power of two.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (wr_en) begin
            r_ptr <= r_ptr + LOG2N'(1);
        end
    end

    // Storage carries no reset; stale contents are masked by the parent
    // until the window has been refilled.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            r_mem[r_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_ptr];

endmodule : sigma_np_dly
`default_nettype wire

// File: rtl/sigma_np.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_np
//  Description : Sum of N = 2^LOG2N samples, either as consecutive blocks
//                (MODE=0) or as a moving window (MODE=1). Samples are taken
//                on rising edges of syn_in, converted to two's complement
//                and accumulated at exact width.
//  Ports       : clk      - clock
//                res      - asynchronous active-low reset
//                data_in  - sample (sign-magnitude or two's complement)
//                syn_in   - sample strobe, rising edge significant
//                clr      - synchronous restart of accumulation
//                data_out - two's-complement sum, DW+LOG2N bits
//                syn_out  - one-cycle pulse on each new data_out
//                primed   - moving window holds N valid samples (MODE=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module sigma_np
    import sigma_pkg::*;
#(
    parameter int DW     = 8,
    parameter int LOG2N  = 4,
    parameter int MODE   = c_mode_block,
    parameter int IN_FMT = c_fmt_sign_mag
) (
    input  logic                              clk,
    input  logic                              res,
    input  logic [DW-1:0]                     data_in,
    input  logic                              syn_in,
    input  logic                              clr,
    output logic [out_width(DW, LOG2N)-1:0]   data_out,
    output logic                              syn_out,
    output logic                              primed
);

    localparam int               OW         = out_width(DW, LOG2N);
    localparam logic [LOG2N-1:0] c_cnt_last = '1;

    logic             r_syn_d;
    logic             w_evt;
    logic             r_evt;
    logic [DW-1:0]    w_conv;
    logic [OW-1:0]    r_conv;
    logic [OW-1:0]    r_sum;
    logic [OW-1:0]    w_sum_nxt;
    logic [LOG2N-1:0] r_cnt;
    logic             w_last;

    assign w_evt  = syn_in & ~r_syn_d;
    assign w_last = (r_cnt == c_cnt_last);

    // Any legal sample fits in DW bits of two's complement, including the
    // sign-magnitude range; -0 negates to 0 on its own.
    generate
        if (IN_FMT == c_fmt_twos_comp) begin : g_fmt_tc
            assign w_conv = data_in;
        end else begin : g_fmt_sm
            assign w_conv = data_in[DW-1] ? -{1'b0, data_in[DW-2:0]}
                                          :  {1'b0, data_in[DW-2:0]};
        end
    endgenerate

    // Front end: edge detect and sample capture. History resets to 1 so a
    // strobe held high across reset release is not an event. An event on a
    // clr edge is dropped here.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_syn_d <= 1'b1;
            r_evt   <= 1'b0;
            r_conv  <= '0;
        end else begin
            r_syn_d <= syn_in;
            r_evt   <= w_evt & ~clr;
            if (w_evt) begin
                r_conv <= {{LOG2N{w_conv[DW-1]}}, w_conv};
            end
        end
    end

    // Back end runs one cycle after the event. A pending event still
    // produces its output on a clr edge; clr only wipes the state.
    generate
        if (MODE == c_mode_slide) begin : g_slide
            logic [DW-1:0] w_oldest_raw;
            logic [OW-1:0] w_oldest;
            logic          r_primed;

            sigma_np_dly #(
                .DW    (DW),
                .LOG2N (LOG2N)
            ) u_dly (
                .clk     (clk),
                .res     (res),
                .clr     (clr),
                .wr_en   (r_evt),
                .wr_data (r_conv[DW-1:0]),
                .rd_data (w_oldest_raw)
            );

            // Until the window is full, the slot being overwritten has not
            // been written since reset/clr and counts as zero.
            assign w_oldest  = r_primed ? {{LOG2N{w_oldest_raw[DW-1]}}, w_oldest_raw}
                                        : '0;
            assign w_sum_nxt = r_sum + r_conv - w_oldest;
            assign primed    = r_primed;

            always_ff @(posedge clk or negedge res) begin
                if (!res) begin
                    r_sum    <= '0;
                    r_cnt    <= '0;
                    r_primed <= 1'b0;
                    data_out <= '0;
                    syn_out  <= 1'b0;
                end else begin
                    syn_out <= 1'b0;
                    if (r_evt && (r_primed || w_last)) begin
                        data_out <= w_sum_nxt;
                        syn_out  <= 1'b1;
                    end
                    if (clr) begin
                        r_sum    <= '0;
                        r_cnt    <= '0;
                        r_primed <= 1'b0;
                    end else if (r_evt) begin
                        r_sum <= w_sum_nxt;
                        if (!r_primed) begin
                            r_cnt <= r_cnt + LOG2N'(1);
                            if (w_last) begin
                                r_primed <= 1'b1;
                            end
                        end
                    end
                end
            end
        end else begin : g_block
            assign w_sum_nxt = r_sum + r_conv;
            assign primed    = 1'b0;

            always_ff @(posedge clk or negedge res) begin
                if (!res) begin
                    r_sum    <= '0;
                    r_cnt    <= '0;
                    data_out <= '0;
                    syn_out  <= 1'b0;
                end else begin
                    syn_out <= 1'b0;
                    if (r_evt && w_last) begin
                        data_out <= w_sum_nxt;
                        syn_out  <= 1'b1;
                    end
                    if (clr) begin
                        r_sum <= '0;
                        r_cnt <= '0;
                    end else if (r_evt) begin
                        if (w_last) begin
                            r_sum <= '0;
                            r_cnt <= '0;
                        end else begin
                            r_sum <= w_sum_nxt;
                            r_cnt <= r_cnt + LOG2N'(1);
                        end
                    end
                end
            end
        end
    endgenerate

endmodule : sigma_np
`default_nettype wire
